// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter
// Merges two pixel-write streams (A: obstacle drawer, B: player drawer) onto the
// single write port of the VGA adapter. Each source feeds its own FIFO because
// neither source can be stalled. A round-robin arbiter drains one pixel per cycle
// into a registered output stage.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_a_x/y/color, i_a_write  source A pixel and write strobe
//   i_b_x/y/color, i_b_write  source B pixel and write strobe
//   i_clear_overflow          clears both sticky overflow flags
//   o_out_x/y/color/write     registered pixel write to the VGA adapter
//   o_a_count, o_b_count      FIFO occupancy (0..2^FIFO_ADDR_BITS)
//   o_a_overflow, o_b_overflow sticky: a write from that source was dropped
module pixel_write_arbiter #(
    parameter int unsigned nX             = 10,
    parameter int unsigned nY             = 9,
    parameter int unsigned COLOR_DEPTH    = 9,
    parameter int unsigned FIFO_ADDR_BITS = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [nX-1:0]             i_a_x,
    input  logic [nY-1:0]             i_a_y,
    input  logic [COLOR_DEPTH-1:0]    i_a_color,
    input  logic                      i_a_write,
    input  logic [nX-1:0]             i_b_x,
    input  logic [nY-1:0]             i_b_y,
    input  logic [COLOR_DEPTH-1:0]    i_b_color,
    input  logic                      i_b_write,
    input  logic                      i_clear_overflow,
    output logic [nX-1:0]             o_out_x,
    output logic [nY-1:0]             o_out_y,
    output logic [COLOR_DEPTH-1:0]    o_out_color,
    output logic                      o_out_write,
    output logic [FIFO_ADDR_BITS:0]   o_a_count,
    output logic [FIFO_ADDR_BITS:0]   o_b_count,
    output logic                      o_a_overflow,
    output logic                      o_b_overflow
);

    localparam int unsigned Depth = 1 << FIFO_ADDR_BITS;
    localparam int unsigned PixW  = nX + nY + COLOR_DEPTH;

    typedef logic [FIFO_ADDR_BITS:0] cnt_t;
    typedef logic [PixW-1:0]         pix_t;

    // Which source won the most recent grant; the other one wins the next tie.
    typedef enum logic {GrantA, GrantB} grant_e;

    // Index 0 is source A, index 1 is source B.
    pix_t   r_mem [2][Depth];
    cnt_t   r_wr_cnt [2];
    cnt_t   r_rd_cnt [2];
    logic   r_ovf [2];
    grant_e r_last_grant;
    grant_e w_last_grant_next;
    pix_t   r_out_pix;
    logic   r_out_write;

    pix_t   w_in_pix [2];
    logic   w_in_wr [2];
    cnt_t   w_count [2];
    logic   w_full [2];
    logic   w_empty [2];
    logic   w_push [2];
    logic   w_drop [2];
    logic   w_pop [2];
    pix_t   w_head [2];
    logic   w_grant_a;
    logic   w_grant_b;

    assign w_in_pix[0] = {i_a_x, i_a_y, i_a_color};
    assign w_in_pix[1] = {i_b_x, i_b_y, i_b_color};
    assign w_in_wr[0]  = i_a_write;
    assign w_in_wr[1]  = i_b_write;

    // FIFO status comes only from registered pointers, so a push is not visible
    // to the arbiter until the following cycle.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_count[s] = r_wr_cnt[s] - r_rd_cnt[s];
            w_full[s]  = (w_count[s] == cnt_t'(Depth));
            w_empty[s] = (w_count[s] == '0);
            // Fullness is judged before this edge's pop: a write into a full
            // FIFO is dropped even if that FIFO is drained in the same cycle.
            w_push[s]  = w_in_wr[s] & ~w_full[s];
            w_drop[s]  = w_in_wr[s] & w_full[s];
            w_head[s]  = r_mem[s][r_rd_cnt[s][FIFO_ADDR_BITS-1:0]];
        end
    end

    // Round-robin arbiter: next-state and grant decode.
    always_comb begin
        w_last_grant_next = r_last_grant;
        w_grant_a         = 1'b0;
        w_grant_b         = 1'b0;
        if (!w_empty[0] && (w_empty[1] || r_last_grant == GrantB)) begin
            w_grant_a         = 1'b1;
            w_last_grant_next = GrantA;
        end else if (!w_empty[1]) begin
            w_grant_b         = 1'b1;
            w_last_grant_next = GrantB;
        end
    end

    assign w_pop[0] = w_grant_a;
    assign w_pop[1] = w_grant_b;

    // Arbiter state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_grant <= GrantB;
        end else begin
            r_last_grant <= w_last_grant_next;
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge i_clk) begin
        for (int s = 0; s < 2; s++) begin
            if (w_push[s]) begin
                r_mem[s][r_wr_cnt[s][FIFO_ADDR_BITS-1:0]] <= w_in_pix[s];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int s = 0; s < 2; s++) begin
                r_wr_cnt[s] <= '0;
                r_rd_cnt[s] <= '0;
                r_ovf[s]    <= 1'b0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_push[s]) begin
                    r_wr_cnt[s] <= r_wr_cnt[s] + cnt_t'(1);
                end
                if (w_pop[s]) begin
                    r_rd_cnt[s] <= r_rd_cnt[s] + cnt_t'(1);
                end
                // A drop on the same edge as a clear keeps the flag set.
                if (w_drop[s]) begin
                    r_ovf[s] <= 1'b1;
                end else if (i_clear_overflow) begin
                    r_ovf[s] <= 1'b0;
                end
            end
        end
    end

    // Output register: zeroed whenever nothing is granted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_pix   <= '0;
            r_out_write <= 1'b0;
        end else if (w_grant_a) begin
            r_out_pix   <= w_head[0];
            r_out_write <= 1'b1;
        end else if (w_grant_b) begin
            r_out_pix   <= w_head[1];
            r_out_write <= 1'b1;
        end else begin
            r_out_pix   <= '0;
            r_out_write <= 1'b0;
        end
    end

    assign o_out_x      = r_out_pix[PixW-1 -: nX];
    assign o_out_y      = r_out_pix[COLOR_DEPTH +: nY];
    assign o_out_color  = r_out_pix[COLOR_DEPTH-1:0];
    assign o_out_write  = r_out_write;
    assign o_a_count    = w_count[0];
    assign o_b_count    = w_count[1];
    assign o_a_overflow = r_ovf[0];
    assign o_b_overflow = r_ovf[1];

endmodule
